adder_rr_scheduler: RTL and testbench
=====================================

Name: adder_rr_scheduler

Overview:
Shares one 32-bit adder (operands A/B, carry-in ci, result sum) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Drives the adder's operand port and waits the adder's fixed latency.
- Returns the sum with the requester id on a single valid/ready response channel.
- Sits between client blocks and the adder datapath; one operation in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/sum width
ADD_LATENCY, 0, cycles from operands driven to sum valid (0 = combinational adder, max 7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  packed operand B, same packing
req_ci  in  NUM_REQ  per-requester carry-in
add_a  out  WIDTH  operand A to adder
add_b  out  WIDTH  operand B to adder
add_ci  out  1  carry-in to adder
add_sum  in  WIDTH  sum from adder
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_sum  out  WIDTH  captured sum
rsp_id  out  $clog2(NUM_REQ)  index of the requester that issued the operation

Behaviour:
- Reset (sync, active-high): state=IDLE, rr_ptr=0, add_a/add_b/add_ci=0, rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] asserted combinationally in the same cycle; all other req_ready bits 0.
  - req_ready is 0 in every other state.
  - On acceptance edge: latch req_a/req_b/req_ci[grant] into add_a/add_b/add_ci, latch id, rr_ptr <= (grant+1) mod NUM_REQ, go to CALC with cnt=0.
  - No valid requests: stay IDLE.
- CALC:
  - Lasts exactly ADD_LATENCY+1 cycles; add_* held stable throughout.
  - At the edge ending the last CALC cycle: rsp_sum <= add_sum, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid/rsp_sum/rsp_id stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - The next acceptance happens no earlier than the following cycle.
- Latency: acceptance at end of cycle 0 gives rsp_valid high in cycle ADD_LATENCY+2.
- Throughput: one operation per ADD_LATENCY+3 cycles when rsp_ready is held high.
- Arithmetic: sum is modulo 2^WIDTH (wrap-around) and is taken from add_sum unmodified; the scheduler performs no arithmetic.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A requester deasserting req_valid before acceptance is legal: no grant, no state change.
- Requests arriving during CALC/RESP wait; no request is lost or duplicated.
- Reset in any state: in-flight operation dropped, no response produced, all registers return to reset values on the same edge.
- reset has priority over every other event.

Optional Feature:
ADDER_SCHED_OVF_EN:
- Defined: adds output rsp_ovf (1 bit), captured with rsp_sum.
- rsp_ovf = signed overflow = (add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]).
- rsp_ovf resets to 0.
- Undefined: port and logic absent.

Decomposition:
- Package adder_sched_pkg: state enum (IDLE, CALC, RESP), MAX_REQ=8, the ID width function/constant, latency-counter width (3 bits).
- Sub-module rr_arbiter: combinational; inputs req vector and rr_ptr; outputs one-hot grant and grant index plus any_grant.

Test Plan:
- Single request: req0 A=64, B=128, ci=0, ADD_LATENCY=0, rsp_ready=1 -> rsp_valid in cycle 2, rsp_sum=192, rsp_id=0.
- Wrap-around: A=32'hFFFFFFFF, B=0, ci=1 -> rsp_sum=0; with ADDER_SCHED_OVF_EN, A=32'h7FFFFFFF, B=1 -> rsp_ovf=1.
- Round-robin: all 4 req_valid held high with distinct operands -> grant order 0,1,2,3,0; each id's sum correct.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_sum/rsp_id stable; no req_ready asserted; release -> next grant the following cycle.
- Latency: ADD_LATENCY=3 with a registered-adder model -> add_* stable for 4 CALC cycles, rsp_valid in cycle 5.
- Reset mid-CALC: assert reset in CALC -> next cycle IDLE, rsp_valid=0, rr_ptr=0, no response for the dropped operation.

Source files
------------

// File: rtl/adder_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : adder_sched_pkg                                             |
// | Purpose    : Shared types and constants for the round-robin adder        |
// |              scheduler: FSM state enum, requester limit, id width        |
// |              helper and latency-counter width.                           |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_REQ     = 8;
    localparam int CNT_W       = 3;   // counts CALC cycles 0..ADD_LATENCY (max 7)
    localparam int MAX_LATENCY = 7;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : rr_arbiter                                                  |
// | Purpose    : Combinational round-robin pick. Searches req_i starting at  |
// |              ptr_i and wrapping modulo NUM_REQ; first set bit wins.      |
// | Ports      : req_i        request vector                                 |
// |              ptr_i        highest-priority index this cycle              |
// |              grant_oh_o   one-hot grant (zero when nothing requested)    |
// |              grant_idx_o  binary index of the grant                      |
// |              any_grant_o  at least one request present                   |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               any_grant_o
);

    int w_idx;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_grant_o && req_i[w_idx]) begin
                any_grant_o        = 1'b1;
                grant_oh_o[w_idx]  = 1'b1;
                grant_idx_o        = IDW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : adder_rr_scheduler                                          |
// | Purpose    : Shares one WIDTH-bit adder between NUM_REQ (2..8) clients.  |
// |              Round-robin grant in IDLE, operands held on add_* for       |
// |              ADD_LATENCY+1 cycles in CALC, result returned with the      |
// |              issuing id in RESP. One operation in flight at a time.      |
// | Ports      : clk, reset            clock / sync active-high reset        |
// |              req_valid/req_ready   per-requester handshake               |
// |              req_a/req_b/req_ci    packed operands, slot i at i*WIDTH    |
// |              add_a/add_b/add_ci    operands to the external adder        |
// |              add_sum               result from the external adder        |
// |              rsp_valid/rsp_ready   response handshake                    |
// |              rsp_sum/rsp_id        captured sum and issuing requester    |
// |              rsp_ovf               signed overflow (optional)            |
// | Options    : ADDER_SCHED_OVF_EN adds the rsp_ovf output and its logic.   |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int ADD_LATENCY = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_ci,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_ci,
    input  logic [WIDTH-1:0]           add_sum,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef ADDER_SCHED_OVF_EN
    ,
    output logic                       rsp_ovf
`endif
);

    localparam int IDW = id_width(NUM_REQ);

    state_t             state_q,     state_d;
    logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0]   add_a_q,     add_a_d;
    logic [WIDTH-1:0]   add_b_q,     add_b_d;
    logic               add_ci_q,    add_ci_d;
    logic [IDW-1:0]     id_q,        id_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_sum_q,   rsp_sum_d;
    logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
`ifdef ADDER_SCHED_OVF_EN
    logic               rsp_ovf_q,   rsp_ovf_d;
`endif

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_any_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (w_grant_oh),
        .grant_idx_o (w_grant_idx),
        .any_grant_o (w_any_grant)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_ci_d    = add_ci_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
`ifdef ADDER_SCHED_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                req_ready = w_grant_oh;
                if (w_any_grant) begin
                    add_a_d  = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
                    add_b_d  = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
                    add_ci_d = req_ci[w_grant_idx];
                    id_d     = w_grant_idx;
                    // Winner drops to lowest priority for the next search.
                    if (w_grant_idx == IDW'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = w_grant_idx + 1'b1;
                    end
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(ADD_LATENCY)) begin
                    rsp_sum_d   = add_sum;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
`ifdef ADDER_SCHED_OVF_EN
                    rsp_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != add_a_q[WIDTH-1]);
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No handshake may complete while reset is held.
        if (reset) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
            id_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
`ifdef ADDER_SCHED_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ci_q    <= add_ci_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
`ifdef ADDER_SCHED_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_ci    = add_ci_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
`ifdef ADDER_SCHED_OVF_EN
    assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_adder_rr_scheduler                                       |
// | Purpose    : Self-checking bench for adder_rr_scheduler. u_dut0 uses a   |
// |              combinational adder (ADD_LATENCY=0); u_dut3 uses a 3-stage  |
// |              registered adder (ADD_LATENCY=3). Expected grants come from |
// |              a pointer-based round-robin model; expected sums from plain |
// |              modular arithmetic. ADDER_SCHED_OVF_EN enables rsp_ovf.     |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_adder_rr_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT with combinational adder ----------------
    logic [3:0]   req_valid0, req_ready0, req_ci0;
    logic [127:0] req_a0, req_b0;
    logic [31:0]  add_a0, add_b0, add_sum0, rsp_sum0;
    logic         add_ci0, rsp_valid0, rsp_ready0;
    logic [1:0]   rsp_id0;
`ifdef ADDER_SCHED_OVF_EN
    logic         rsp_ovf0, rsp_ovf3;
`endif

    logic [31:0] a_arr [4];
    logic [31:0] b_arr [4];
    logic        ci_arr[4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a0[i*32 +: 32] = a_arr[i];
            req_b0[i*32 +: 32] = b_arr[i];
            req_ci0[i]         = ci_arr[i];
        end
    end

    assign add_sum0 = add_a0 + add_b0 + {31'b0, add_ci0};

    adder_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .ADD_LATENCY(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_a     (req_a0),
        .req_b     (req_b0),
        .req_ci    (req_ci0),
        .add_a     (add_a0),
        .add_b     (add_b0),
        .add_ci    (add_ci0),
        .add_sum   (add_sum0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_sum   (rsp_sum0),
        .rsp_id    (rsp_id0)
`ifdef ADDER_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf0)
`endif
    );

    // ---------------- DUT with 3-cycle registered adder ----------------
    logic [3:0]   req_valid3, req_ready3;
    logic [31:0]  a3, b3;
    logic         ci3;
    logic [31:0]  add_a3, add_b3, add_sum3, rsp_sum3;
    logic         add_ci3, rsp_valid3, rsp_ready3;
    logic [1:0]   rsp_id3;
    logic [31:0]  p3_0, p3_1, p3_2;

    always @(posedge clk) begin
        p3_0 <= add_a3 + add_b3 + {31'b0, add_ci3};
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign add_sum3 = p3_2;

    adder_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .ADD_LATENCY(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_a     ({96'b0, a3}),
        .req_b     ({96'b0, b3}),
        .req_ci    ({3'b0, ci3}),
        .add_a     (add_a3),
        .add_b     (add_b3),
        .add_ci    (add_ci3),
        .add_sum   (add_sum3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_sum   (rsp_sum3),
        .rsp_id    (rsp_id3)
`ifdef ADDER_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf3)
`endif
    );

    // ---------------- checking infrastructure ----------------
    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // First valid requester at or after the pointer, wrapping.
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    // One complete operation on u_dut0 with rsp_ready held high.
    task automatic serve(input bit drop, output int waited);
        int          g;
        logic [3:0]  oh;
        logic [31:0] ea, eb, es;
        waited = 0;
        #1;
        while (req_ready0 === 4'b0 && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_wait_bound", 64'(waited < 20), 64'd1);
        if (waited >= 20) return;
        g  = model_grant(req_valid0, model_ptr);
        oh = 4'b0001 << g;
        check("req_ready_onehot", 64'(req_ready0), 64'(oh));
        ea = a_arr[g];
        eb = b_arr[g];
        es = a_arr[g] + b_arr[g] + {31'b0, ci_arr[g]};
        model_ptr = (g + 1) % 4;
        tick();                                   // first CALC cycle
        if (drop) begin
            req_valid0[g] = 1'b0;
        end else begin
            a_arr[g]  = $urandom;
            b_arr[g]  = $urandom;
            ci_arr[g] = 1'($urandom_range(1));
        end
        check("calc_add_a", 64'(add_a0), 64'(ea));
        check("calc_rsp_valid", 64'(rsp_valid0), 64'd0);
        check("calc_req_ready", 64'(req_ready0), 64'd0);
        tick();                                   // response cycle
        check("rsp_valid", 64'(rsp_valid0), 64'd1);
        check("rsp_sum", 64'(rsp_sum0), 64'(es));
        check("rsp_id", 64'(rsp_id0), 64'(g));
`ifdef ADDER_SCHED_OVF_EN
        check("rsp_ovf", 64'(rsp_ovf0),
              64'((ea[31] == eb[31]) && (es[31] != ea[31])));
`endif
        tick();                                   // back in IDLE
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          g;
        logic [3:0]  oh;
        logic [31:0] es;
        logic [1:0]  eid;

        reset      = 1'b1;
        req_valid0 = '0;
        rsp_ready0 = 1'b1;
        req_valid3 = '0;
        rsp_ready3 = 1'b1;
        a3 = '0; b3 = '0; ci3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0; b_arr[i] = '0; ci_arr[i] = 1'b0;
        end

        // ---- reset state ----
        tick(); tick();
        check("rst_rsp_valid", 64'(rsp_valid0), 64'd0);
        check("rst_req_ready", 64'(req_ready0), 64'd0);
        check("rst_add_a", 64'(add_a0), 64'd0);
        check("rst_add_b", 64'(add_b0), 64'd0);
        check("rst_add_ci", 64'(add_ci0), 64'd0);
        check("rst_rsp_sum", 64'(rsp_sum0), 64'd0);
        check("rst_rsp_id", 64'(rsp_id0), 64'd0);
        check("rst_rsp_valid3", 64'(rsp_valid3), 64'd0);
        reset = 1'b0;
        tick();

        // ---- single request: 64 + 128 ----
        a_arr[0] = 32'd64; b_arr[0] = 32'd128; ci_arr[0] = 1'b0;
        req_valid0 = 4'b0001;
        serve(1'b1, w);
        check("single_no_wait", 64'(w), 64'd0);

        // ---- wrap-around and signed overflow ----
        a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h0; ci_arr[0] = 1'b1;
        req_valid0 = 4'b0001;
        serve(1'b1, w);
        a_arr[0] = 32'h7FFF_FFFF; b_arr[0] = 32'h1; ci_arr[0] = 1'b0;
        req_valid0 = 4'b0001;
        serve(1'b1, w);

        // ---- random mixed requests ----
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) begin
                a_arr[i]  = $urandom;
                b_arr[i]  = $urandom;
                ci_arr[i] = 1'($urandom_range(1));
            end
            req_valid0 = req_valid0 | 4'($urandom_range(15)) | (4'b0001 << $urandom_range(3));
            serve(1'b1, w);
        end
        req_valid0 = '0;
        tick();

        // ---- backpressure: requesters 1 and 2, response held 5 cycles ----
        rsp_ready0 = 1'b0;
        for (int i = 1; i < 3; i++) begin
            a_arr[i] = $urandom; b_arr[i] = $urandom; ci_arr[i] = 1'($urandom_range(1));
        end
        req_valid0 = 4'b0110;
        #1;
        g  = model_grant(req_valid0, model_ptr);
        oh = 4'b0001 << g;
        check("bp_req_ready", 64'(req_ready0), 64'(oh));
        es  = a_arr[g] + b_arr[g] + {31'b0, ci_arr[g]};
        eid = 2'(g);
        model_ptr = (g + 1) % 4;
        tick();
        req_valid0[g] = 1'b0;
        tick();
        check("bp_rsp_valid", 64'(rsp_valid0), 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 64'(rsp_valid0), 64'd1);
            check("bp_hold_sum", 64'(rsp_sum0), 64'(es));
            check("bp_hold_id", 64'(rsp_id0), 64'(eid));
            check("bp_no_ready", 64'(req_ready0), 64'd0);
        end
        rsp_ready0 = 1'b1;
        tick();
        check("bp_released", 64'(rsp_valid0), 64'd0);
        serve(1'b1, w);
        check("bp_next_grant_wait", 64'(w), 64'd0);

        // ---- reset mid-CALC drops the operation and the pointer ----
        a_arr[1] = 32'd5; b_arr[1] = 32'd7; ci_arr[1] = 1'b0;
        req_valid0 = 4'b0010;
        #1;
        check("mid_req_ready", 64'(req_ready0), 64'b0010);
        tick();
        req_valid0 = '0;
        check("mid_calc_valid", 64'(rsp_valid0), 64'd0);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 64'(rsp_valid0), 64'd0);
        check("mid_rst_add_a", 64'(add_a0), 64'd0);
        check("mid_rst_ready", 64'(req_ready0), 64'd0);
        reset = 1'b0;
        model_ptr = 0;
        tick();
        check("mid_no_rsp_a", 64'(rsp_valid0), 64'd0);
        tick();
        check("mid_no_rsp_b", 64'(rsp_valid0), 64'd0);

        // ---- round robin with all requesters held high: 0,1,2,3,0 ----
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = $urandom; b_arr[i] = $urandom; ci_arr[i] = 1'($urandom_range(1));
        end
        req_valid0 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            check("rr_model_order", 64'(model_grant(req_valid0, model_ptr)), 64'(n % 4));
            serve(1'b0, w);
            check("rr_back_to_back", 64'(w), 64'd0);
        end
        req_valid0 = '0;
        tick();

        // ---- latency 3 with registered adder ----
        a3 = $urandom; b3 = $urandom; ci3 = 1'b1;
        req_valid3 = 4'b0001;
        #1;
        check("lat3_req_ready", 64'(req_ready3), 64'b0001);
        tick();
        req_valid3 = '0;
        for (int c = 1; c <= 4; c++) begin
            check("lat3_add_a_stable", 64'(add_a3), 64'(a3));
            check("lat3_add_b_stable", 64'(add_b3), 64'(b3));
            check("lat3_calc_valid", 64'(rsp_valid3), 64'd0);
            tick();
        end
        check("lat3_rsp_valid", 64'(rsp_valid3), 64'd1);
        check("lat3_rsp_sum", 64'(rsp_sum3), 64'(a3 + b3 + 32'd1));
        check("lat3_rsp_id", 64'(rsp_id3), 64'd0);
        tick();
        check("lat3_consumed", 64'(rsp_valid3), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
